sysarr_feeder: RTL and testbench

// - Upstream stage of the 4x4 systolic multiplier array. Buffers operand matrices A (rows -> left edge)
//   and B (columns -> top edge), then streams them diagonally skewed into the array edge inputs.
// - Generates the array clear (arr_rst), sequences feed/drain and signals completion so the

---
 rtl/sysarr_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_sysarr_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_feeder.sv
// ============================================================================
// sysarr_feeder
// ----------------------------------------------------------------------------
// Upstream stage of the NxN systolic multiplier array (verified for N = 4).
// Buffers operand matrices A and B, clears the array, then streams A rows
// into the left edge and B columns into the top edge with a diagonal skew so
// that matching operands meet in the right PE.  After the feed, the array is
// given N drain cycles, and done pulses once the array's result registers hold
// C = A*B.
//
// Sequence:  IDLE -(start)-> CLEAR (1) -> FEED (2N-1) -> DRAIN (N) -> DONE (1)
//
// Optional feature (compile-time macro SYSFEED_ACCUM_EN):
//   Adds the 'accum' input, sampled together with start.  accum=1 skips
//   CLEAR, so the array keeps its previous results and accumulates
//   C += A*B.  accum=0 behaves exactly like the build without the macro.
//
// Parameters:
//   N   array dimension (lanes; each buffer holds N*N elements)
//   DW  element width, equal to the array PE data width
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset; aborts a run immediately
//   wr_en    in   buffer write strobe, honoured only in IDLE
//   wr_sel   in   0 = matrix A, 1 = matrix B
//   wr_addr  in   element index row*N+col
//   wr_data  in   element value
//   start    in   begin a run, honoured only in IDLE
//   accum    in   (SYSFEED_ACCUM_EN only) accumulate instead of clearing
//   busy     out  1 in every state except IDLE
//   done     out  one-cycle pulse in DONE
//   arr_rst  out  array reset: 1 in CLEAR and while rst is high
//   l_out    out  left edge, lane i [i*DW +: DW] drives array row i+1
//   u_out    out  top edge, lane j [j*DW +: DW] drives array column j+1
// ============================================================================
module sysarr_feeder #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(N*N)-1:0]   wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     start,
`ifdef SYSFEED_ACCUM_EN
    input  logic                     accum,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     arr_rst,
    output logic [N*DW-1:0]          l_out,
    output logic [N*DW-1:0]          u_out
);

    localparam int AW = $clog2(N*N);
    localparam int SW = $clog2(2*N-1);

    localparam logic [SW-1:0] LAST_FEED  = SW'(2*N-2);
    localparam logic [SW-1:0] LAST_DRAIN = SW'(N-1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [SW-1:0]   step;
    logic [SW-1:0]   step_next;

    logic [DW-1:0]   a_buf  [N*N];
    logic [DW-1:0]   b_buf  [N*N];
    logic [DW-1:0]   a_view [N*N];
    logic [DW-1:0]   b_view [N*N];

    logic            wr_hit;
    logic [N*DW-1:0] feed_l;
    logic [N*DW-1:0] feed_u;

    assign wr_hit  = wr_en && (state == S_IDLE);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign arr_rst = rst || (state == S_CLEAR);

    // Operand buffers are not reset; writes outside IDLE are dropped.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            if (wr_sel) begin
                b_buf[wr_addr] <= wr_data;
            end else begin
                a_buf[wr_addr] <= wr_data;
            end
        end
    end

    // Buffer contents as they will be after this edge.  The accumulate path
    // loads feed step 0 straight out of IDLE, on the same edge as a possible
    // write, so the write is forwarded to keep "write + start" coherent.
    always_comb begin
        for (int e = 0; e < N*N; e++) begin
            a_view[e] = a_buf[e];
            b_view[e] = b_buf[e];
        end
        if (wr_hit) begin
            if (wr_sel) begin
                b_view[wr_addr] = wr_data;
            end else begin
                a_view[wr_addr] = wr_data;
            end
        end
    end

    // Next state and step counter.  The counter indexes feed steps in FEED
    // and counts drain cycles in DRAIN; it rests at 0 elsewhere.
    always_comb begin
        state_next = state;
        step_next  = step;
        case (state)
            S_IDLE: begin
                step_next = '0;
                if (start) begin
`ifdef SYSFEED_ACCUM_EN
                    state_next = accum ? S_FEED : S_CLEAR;
`else
                    state_next = S_CLEAR;
`endif
                end
            end
            S_CLEAR: begin
                state_next = S_FEED;
                step_next  = '0;
            end
            S_FEED: begin
                if (step == LAST_FEED) begin
                    state_next = S_DRAIN;
                    step_next  = '0;
                end else begin
                    step_next = step + 1'b1;
                end
            end
            S_DRAIN: begin
                if (step == LAST_DRAIN) begin
                    state_next = S_DONE;
                    step_next  = '0;
                end else begin
                    step_next = step + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                step_next  = '0;
            end
            default: begin
                state_next = S_IDLE;
                step_next  = '0;
            end
        endcase
    end

    // Skewed edge values for the step about to be presented: lane i carries
    // A[i][d] and B[d][i] where d = step - i, zero outside the matrix.
    always_comb begin
        feed_l = '0;
        feed_u = '0;
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < N; d++) begin
                if (int'(step_next) == i + d) begin
                    feed_l[i*DW +: DW] = a_view[i*N + d];
                    feed_u[i*DW +: DW] = b_view[d*N + i];
                end
            end
        end
    end

    // Edge outputs are registered from the next state so each element sits
    // on the array edge for exactly the one FEED cycle it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= '0;
            l_out <= '0;
            u_out <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
            if (state_next == S_FEED) begin
                l_out <= feed_l;
                u_out <= feed_u;
            end else begin
                l_out <= '0;
                u_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sysarr_feeder.sv
`timescale 1ns/1ps
// Bench for sysarr_feeder: a cycle-by-cycle scoreboard of expected outputs
// is filled whenever a run is launched and drained one record per clock,
// plus a table of specific feed-edge values for the identity/ramp load.
module tb_sysarr_feeder;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int W  = N*DW;

   localparam int ST_IDLE  = 0;
   localparam int ST_CLEAR = 1;
   localparam int ST_FEED  = 2;
   localparam int ST_DRAIN = 3;
   localparam int ST_DONE  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
`ifdef SYSFEED_ACCUM_EN
   logic          accum;
`endif
   logic          busy;
   logic          done;
   logic          arr_rst;
   logic [W-1:0]  l_out;
   logic [W-1:0]  u_out;

   typedef struct {
      int           st;
      int           step;
      logic         busy;
      logic         done;
      logic         arr;
      logic [W-1:0] l;
      logic [W-1:0] u;
   } exp_t;

   typedef struct {
      int            step;
      int            lane;
      logic [DW-1:0] l;
      logic [DW-1:0] u;
   } vec_t;

   exp_t          sb[$];
   vec_t          vecs[6];
   logic [DW-1:0] ma [N*N];
   logic [DW-1:0] mb [N*N];
   logic [W-1:0]  cap_l [2*N-1];
   logic [W-1:0]  cap_u [2*N-1];

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int cur_state = ST_IDLE;

   sysarr_feeder #(.N(N), .DW(DW)) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_sel(wr_sel),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .start(start),
`ifdef SYSFEED_ACCUM_EN
      .accum(accum),
`endif
      .busy(busy),
      .done(done),
      .arr_rst(arr_rst),
      .l_out(l_out),
      .u_out(u_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int st, input int step, input logic b, input logic d, input logic a);
      exp_t e;
      e.st   = st;
      e.step = step;
      e.busy = b;
      e.done = d;
      e.arr  = a;
      e.l    = '0;
      e.u    = '0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, want);
      end
   endtask

   // Queue the per-cycle expectations of one run, computed from the bench's
   // own copy of A and B using the skew rule d = k - lane.
   task automatic pushRun(input logic acc);
      exp_t e;
      int   d;
      if (!acc) sb.push_back(mk(ST_CLEAR, 0, 1'b1, 1'b0, 1'b1));
      for (int k = 0; k < 2*N-1; k++) begin
         e = mk(ST_FEED, k, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < N; i++) begin
            d = k - i;
            if (d >= 0 && d < N) begin
               e.l[i*DW +: DW] = ma[i*N + d];
               e.u[i*DW +: DW] = mb[d*N + i];
            end
         end
         sb.push_back(e);
      end
      for (int k = 0; k < N; k++) sb.push_back(mk(ST_DRAIN, k, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk(ST_DONE, 0, 1'b1, 1'b1, 1'b0));
   endtask

   // Advance one clock and compare the cycle that follows the edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cur_state = e.st;
         if (e.st == ST_FEED) begin
            cap_l[e.step] = l_out;
            cap_u[e.step] = u_out;
         end
      end else begin
         e = mk(ST_IDLE, 0, 1'b0, 1'b0, rst);
         cur_state = ST_IDLE;
      end
      checkOutput("busy",    W'(busy),    W'(e.busy));
      checkOutput("done",    W'(done),    W'(e.done));
      checkOutput("arr_rst", W'(arr_rst), W'(e.arr));
      checkOutput("l_out",   l_out,       e.l);
      checkOutput("u_out",   u_out,       e.u);
   endtask

   task automatic applyStimulus(input logic r, input logic we, input logic sel,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic st, input logic acc);
      rst     = r;
      wr_en   = we;
      wr_sel  = sel;
      wr_addr = addr;
      wr_data = data;
      start   = st;
`ifdef SYSFEED_ACCUM_EN
      accum   = acc;
`endif
      if (r) begin
         sb.delete();
      end else if (cur_state == ST_IDLE) begin
         if (we) begin
            if (sel) mb[addr] = data;
            else     ma[addr] = data;
         end
         if (st) pushRun(acc);
      end
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic writeElem(input logic sel, input int addr, input int data);
      applyStimulus(1'b0, 1'b1, sel, AW'(addr), DW'(data), 1'b0, 1'b0);
   endtask

   task automatic startRun(input logic acc);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
   endtask

   initial begin
      vecs[0] = '{step:0, lane:0, l:32'd1, u:32'd1};
      vecs[1] = '{step:0, lane:1, l:32'd0, u:32'd0};
      vecs[2] = '{step:0, lane:2, l:32'd0, u:32'd0};
      vecs[3] = '{step:0, lane:3, l:32'd0, u:32'd0};
      vecs[4] = '{step:3, lane:3, l:32'd0, u:32'd4};
      vecs[5] = '{step:6, lane:3, l:32'd1, u:32'd16};

      $display("[TB] reset");
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      idle(2);

      $display("[TB] load A=I, B[r][c]=4r+c+1");
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            writeElem(1'b0, r*N + c, (r == c) ? 1 : 0);
            writeElem(1'b1, r*N + c, 4*r + c + 1);
         end
      end

      $display("[TB] basic run");
      startRun(1'b0);
      idle(14);
      for (int v = 0; v < 6; v++) begin
         checkOutput($sformatf("step%0d_l_lane%0d", vecs[v].step, vecs[v].lane),
                     W'(cap_l[vecs[v].step][vecs[v].lane*DW +: DW]), W'(vecs[v].l));
         checkOutput($sformatf("step%0d_u_lane%0d", vecs[v].step, vecs[v].lane),
                     W'(cap_u[vecs[v].step][vecs[v].lane*DW +: DW]), W'(vecs[v].u));
      end

      $display("[TB] write during FEED is dropped");
      startRun(1'b0);
      idle(2);
      writeElem(1'b0, 0, 99);
      idle(12);
      startRun(1'b0);
      idle(14);
      checkOutput("old_a00_step0", W'(cap_l[0][DW-1:0]), W'(32'd1));
      writeElem(1'b0, 0, 99);
      startRun(1'b0);
      idle(14);
      checkOutput("new_a00_step0", W'(cap_l[0][DW-1:0]), W'(32'd99));
      writeElem(1'b0, 0, 1);

      $display("[TB] write and start in the same cycle");
      applyStimulus(1'b0, 1'b1, 1'b1, AW'(5), DW'(77), 1'b1, 1'b0);
      idle(14);
      checkOutput("b11_step2_u_lane1", W'(cap_u[2][DW +: DW]), W'(32'd77));
      writeElem(1'b1, 5, 6);

      $display("[TB] start during CLEAR and DRAIN is ignored");
      startRun(1'b0);
      startRun(1'b0);
      idle(7);
      startRun(1'b0);
      idle(14);

      $display("[TB] reset during FEED step 3");
      startRun(1'b0);
      idle(4);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      idle(3);
      startRun(1'b0);
      idle(14);

      $display("[TB] start held through DONE");
      repeat (15) startRun(1'b0);
      idle(14);

`ifdef SYSFEED_ACCUM_EN
      $display("[TB] accumulate run");
      startRun(1'b0);
      idle(14);
      startRun(1'b1);
      idle(14);
`endif

      for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
      checkOutput("scoreboard_empty", W'(sb.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
